// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters into a single registered FIFO write port.
// Define FIFO_ARB_BURST_EN to let a winner keep the grant for up to BURST_LEN consecutive beats.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [NUM_REQ*WIDTH-1:0]   i_ReqData,
  output logic [NUM_REQ-1:0]         o_Ack,
  output logic [NUM_REQ-1:0]         o_Grant,
  output logic                       o_WrEn,
  output logic [WIDTH-1:0]           o_WrData,
  input  logic                       i_Full,
  input  logic                       i_ProgFull
);

  localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0]  BURST_L = 5'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, OWN, STALL} state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_ptr, w_ptr_nxt;
  logic [PW-1:0]       r_owner, w_owner_nxt;
  logic [4:0]          r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic                r_wr_en;
  logic [WIDTH-1:0]    r_wr_data;

  logic                w_throttle;
  logic                w_any;
  logic [PW-1:0]       w_winner;
  logic                w_beat;
  logic [PW-1:0]       w_beat_src;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    next_idx = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [PW-1:0] idx);
    one_hot      = '0;
    one_hot[idx] = 1'b1;
  endfunction

  assign w_throttle = i_Full | i_ProgFull;

  // Scan from the highest offset down so the requester closest to r_ptr is the last (winning) hit.
  always_comb begin
    int idx;
    // NOTE: every combinationally written signal gets a default first so no path leaves it unassigned (no latch).
    w_any    = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (i_Req[idx]) begin
        w_any    = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_beat      = 1'b0;
    w_beat_src  = r_owner;

    unique case (r_state)
      IDLE: begin
        if (!w_throttle && w_any) begin
          w_beat     = 1'b1;
          w_beat_src = w_winner;
`ifdef FIFO_ARB_BURST_EN
          if (BURST_L == 5'd1) begin
            w_ptr_nxt = next_idx(w_winner);
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = OWN;
            w_owner_nxt = w_winner;
            w_grant_nxt = one_hot(w_winner);
            w_cnt_nxt   = 5'd1;
          end
`else
          w_ptr_nxt = next_idx(w_winner);
          w_cnt_nxt = '0;
`endif
        end
      end

      OWN: begin
        if (!i_Req[r_owner]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = next_idx(r_owner);
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (w_throttle) begin
          w_state_nxt = STALL;
        end else begin
          w_beat    = 1'b1;
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt + 5'd1 == BURST_L) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = next_idx(r_owner);
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
      end

      STALL: begin
        // Leaving STALL costs one cycle with no beat; the beat resumes from OWN.
        if (!i_Req[r_owner]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = next_idx(r_owner);
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (!w_throttle) begin
          w_state_nxt = OWN;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_Ack    = (w_beat && !i_Rst) ? one_hot(w_beat_src) : '0;
  assign o_Grant  = r_grant;
  assign o_WrEn   = r_wr_en;
  assign o_WrData = r_wr_data;

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_Rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_wr_en <= w_beat;
      if (w_beat) r_wr_data <= i_ReqData[int'(w_beat_src)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter, checked against a transaction-level model.
// The model follows FIFO_ARB_BURST_EN the same way the design does.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int BURST_LEN = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     i_Rst = 1'b1;
  logic [NUM_REQ-1:0]       i_Req = '0;
  logic [NUM_REQ*WIDTH-1:0] i_ReqData = '0;
  logic                     i_Full = 1'b0;
  logic                     i_ProgFull = 1'b0;
  logic [NUM_REQ-1:0]       o_Ack;
  logic [NUM_REQ-1:0]       o_Grant;
  logic                     o_WrEn;
  logic [WIDTH-1:0]         o_WrData;

  int checks = 0;
  int errors = 0;

  // Model of the arbitration contract: current owner (-1 = none), beats served, stall flag, pointer.
  int         m_owner = -1;
  int         m_beats = 0;
  int         m_ptr   = 0;
  bit         m_stall = 1'b0;
  logic       m_wren  = 1'b0;
  logic [7:0] m_data  = '0;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .BURST_LEN(BURST_LEN)) dut (
    .i_Clk      (clk),
    .i_Rst      (i_Rst),
    .i_Req      (i_Req),
    .i_ReqData  (i_ReqData),
    .o_Ack      (o_Ack),
    .o_Grant    (o_Grant),
    .o_WrEn     (o_WrEn),
    .o_WrData   (o_WrData),
    .i_Full     (i_Full),
    .i_ProgFull (i_ProgFull)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check o_Ack before the edge, check registered outputs after it.
  task automatic step(input logic [3:0] req, input bit full, input bit pfull, input bit rst);
    int         who;
    bit         rel;
    bit         thr;
    logic [7:0] beat_data;
    logic [3:0] exp_ack;
    @(negedge clk);
    i_Req      = req;
    i_Full     = full;
    i_ProgFull = pfull;
    i_Rst      = rst;
    for (int n = 0; n < NUM_REQ; n++) i_ReqData[n*WIDTH +: WIDTH] = 8'($urandom);
    #1;
    who = -1;
    rel = 1'b0;
    thr = full | pfull;
    if (!rst) begin
      if (m_owner < 0) begin
        if (!thr) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (who < 0 && req[(m_ptr + k) % NUM_REQ]) who = (m_ptr + k) % NUM_REQ;
          end
        end
      end else if (!req[m_owner]) begin
        rel = 1'b1;
      end else if (m_stall) begin
        if (!thr) m_stall = 1'b0;
      end else if (thr) begin
        m_stall = 1'b1;
      end else begin
        who = m_owner;
      end
    end
    exp_ack   = (who < 0) ? 4'b0000 : 4'(1 << who);
    beat_data = (who < 0) ? 8'h00 : i_ReqData[who*WIDTH +: WIDTH];
    check("ack", 32'(o_Ack), 32'(exp_ack));
    check("ack_onehot0", 32'($onehot0(o_Ack)), 32'd1);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_stall = 1'b0;
      m_wren  = 1'b0; m_data = '0;
    end else if (who >= 0) begin
      m_wren = 1'b1;
      m_data = beat_data;
      if (m_owner < 0) begin
        m_beats = 1;
        if (BURST && BURST_LEN > 1) m_owner = who;
        else m_ptr = (who + 1) % NUM_REQ;
      end else begin
        m_beats++;
        if (m_beats == BURST_LEN) rel = 1'b1;
      end
    end else begin
      m_wren = 1'b0;
    end
    if (rel && !rst) begin
      m_ptr   = (m_owner + 1) % NUM_REQ;
      m_owner = -1;
      m_beats = 0;
      m_stall = 1'b0;
    end
    #1;
    check("wren", 32'(o_WrEn), 32'(m_wren));
    check("wrdata", 32'(o_WrData), 32'(m_data));
    check("grant", 32'(o_Grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
  endtask

  initial begin
    logic [3:0] r;
    // Reset state.
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("reset_wren", 32'(o_WrEn), 32'd0);
    check("reset_wrdata", 32'(o_WrData), 32'd0);

    // Single request from requester 2 with known data.
    @(negedge clk);
    i_Rst = 1'b0; i_Req = 4'b0100; i_Full = 1'b0; i_ProgFull = 1'b0;
    i_ReqData = 32'h005A_0000;
    #1;
    check("single_ack", 32'(o_Ack), 32'h4);
    @(posedge clk);
    #1;
    check("single_wren", 32'(o_WrEn), 32'd1);
    check("single_wrdata", 32'(o_WrData), 32'h5A);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // All requesters held: round robin order (bursts when enabled).
    for (int c = 0; c < 20; c++) step(4'b1111, 1'b0, 1'b0, 1'b0);

    // Requesters 0 and 1 held, throttle after beat 2 for three cycles.
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0011, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) step(4'b0011, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0, 1'b0);

    // Owner drops request after one beat.
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);

    // Reset during beat 2, then the first grant restarts from requester 0.
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b1100, 1'b0, 1'b0, 1'b0);
    step(4'b1100, 1'b0, 1'b0, 1'b1);
    check("midreset_grant", 32'(o_Grant), 32'd0);
    check("midreset_wren", 32'(o_WrEn), 32'd0);
    step(4'b1010, 1'b0, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional throttle and reset.
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom);
      step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
